// File: rtl/display_scan_ctrl.sv
// Digit-slot refresh timing, scroll offset and frame-aligned arbitration
// between the operand-entry (A) and ALU-result (B) value sources.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_OFF     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               a_valid,
  input  logic signed [15:0] a_data,
  input  logic               b_valid,
  input  logic signed [15:0] b_data,
  output logic               ack_a,
  output logic               ack_b,
  output logic signed [15:0] value,
  output logic               active_src,
  output logic [1:0]         offset,
  output logic [1:0]         digit_sel,
  output logic               slot_tick
);

  localparam int             PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PS_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]  PS_PRE  = PW'(REFRESH_DIV - 2);
  localparam logic [1:0]     OFF_MAX = 2'(MAX_OFF);
  localparam logic           SRC_A   = 1'b0;
  localparam logic           SRC_B   = 1'b1;

  logic [PW-1:0] prescaler;
  logic          last_grant;
  logic          frame_bnd;
  logic          gnt_a;
  logic          gnt_b;
  logic          src_chg;

  // Saturating scroll step; simultaneous left+right presses cancel out.
  function automatic logic [1:0] next_offset(input logic [1:0] cur,
                                             input logic       l,
                                             input logic       r);
    logic [1:0] nxt;
    nxt = cur;
    if (l && r)
      nxt = cur;
    else if (l && (cur < OFF_MAX))
      nxt = cur + 2'd1;
    else if (r && (cur != 2'd0))
      nxt = cur - 2'd1;
    return nxt;
  endfunction

  // Grants only at the frame boundary; ties go to whoever was not served last.
  always_comb begin
    frame_bnd = slot_tick && (digit_sel == 2'd3);
    gnt_a     = frame_bnd && a_valid && (!b_valid || (last_grant == SRC_B));
    gnt_b     = frame_bnd && b_valid && (!a_valid || (last_grant == SRC_A));
    src_chg   = (gnt_a && (active_src != SRC_A)) || (gnt_b && (active_src != SRC_B));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler  <= '0;
      slot_tick  <= 1'b0;
      digit_sel  <= 2'd0;
      offset     <= 2'd0;
      value      <= '0;
      active_src <= SRC_A;
      last_grant <= SRC_B;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
    end else begin
      prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PW'(1);
      // Registered so that it is high exactly while prescaler sits at its last count.
      slot_tick <= (prescaler == PS_PRE);
      if (slot_tick)
        digit_sel <= digit_sel + 2'd1;
      ack_a <= gnt_a;
      ack_b <= gnt_b;
      if (gnt_a) begin
        value      <= a_data;
        active_src <= SRC_A;
        last_grant <= SRC_A;
      end else if (gnt_b) begin
        value      <= b_data;
        active_src <= SRC_B;
        last_grant <= SRC_B;
      end
      // A new owner always starts unscrolled, overriding any button press.
      offset <= src_chg ? 2'd0 : next_offset(offset, btn_l, btn_r);
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Controller that sequences the 4-digit multiplexed seven-segment datapath for the calculator. It generates the digit-slot refresh timing and the digit select, and owns the scroll-window offset driven by left/right button pulses. It also arbitrates two 16-bit value sources (operand entry A, ALU result B) for the shared display, latching a new value only at a frame boundary so digits never tear.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (≥2); simulation uses 4.
MAX_OFF, 2, maximum scroll offset (window shift in digits).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
btn_l  input  1  single-cycle scroll-left pulse (from push_button)
btn_r  input  1  single-cycle scroll-right pulse
a_valid  input  1  source A requests display; held until ack_a
a_data  input  16  source A value (two's complement)
b_valid  input  1  source B requests display; held until ack_b
b_data  input  16  source B value
ack_a  output  1  one-cycle pulse: a_data latched
ack_b  output  1  one-cycle pulse: b_data latched
value  output  16  latched display value (feeds double_dabble)
active_src  output  1  0 = A, 1 = B owns display
offset  output  2  scroll offset to digit mux, 0..MAX_OFF
digit_sel  output  2  anode/digit index to seven_seg (3 = sign slot)
slot_tick  output  1  one-cycle pulse at end of each digit slot

Behaviour:
- Reset (rst=0, async): prescaler=0, digit_sel=0, offset=0, value=0, active_src=0, last_grant=B, ack_a=ack_b=0, slot_tick=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. Registered slot_tick=1 for exactly the cycle in which prescaler==REFRESH_DIV-1.
- digit_sel: increments on the clk edge where slot_tick=1; wraps 3→0. Frame boundary = slot_tick && digit_sel==3.
- Arbitration happens only at a frame boundary, on the same edge that digit_sel wraps to 0:
  - Only a_valid: grant A. Only b_valid: grant B.
  - Both valid: grant the source ≠ last_grant (round-robin). After reset, A wins the first tie.
  - Neither valid: value and active_src are held.
- On grant: value←granted data; active_src←granted; last_grant←granted. ack of the granted source =1 in the following cycle only (registered, 1-cycle latency after the latch edge).
- Requesters drop valid in the cycle after seeing ack. If valid is still high at the next boundary, it is re-arbitrated normally.
- A valid asserted mid-frame waits up to 4·REFRESH_DIV cycles. Data must be stable while valid=1 and ack not yet seen.
- Offset update, every cycle, priority order:
  1. Grant whose source ≠ previous active_src → offset←0 (wins over buttons on the same cycle).
  2. btn_l && btn_r both high → no change.
  3. btn_l && offset<MAX_OFF → offset+1.
  4. btn_r && offset>0 → offset-1.
  5. Otherwise hold. Saturates at both ends; never wraps.
- A grant from the same source as current active_src keeps offset.
- Reset mid-frame: all state returns to reset values immediately. A pending ack is lost; the requester keeps valid and is served after reset release.
- Internal state: prescaler ⌈log2 REFRESH_DIV⌉ bits, digit counter, last_grant flag, ack registers. No other FSM states; every path is a defined transition, no latches.

Test Plan (REFRESH_DIV=4):
1. Reset release, no requests, 32 cycles → slot_tick every 4th cycle; digit_sel 0,1,2,3,0…; value=0, offset=0, no acks.
2. a_valid with a_data=16'h04D2 raised mid-frame → latched at next boundary (value=1234, active_src=0); ack_a one cycle later for 1 cycle; nothing changes before the boundary.
3. a_valid and b_valid both held for 3 boundaries (A=5, B=-7) → grants A, B, A; ack_a/ack_b alternate; value=5, 16'hFFF9, 5.
4. btn_l pulsed 3 times → offset 1, 2, 2 (saturates). btn_r 3 times → 1, 0, 0. btn_l and btn_r on the same cycle → unchanged.
5. offset=2, active A; b_valid granted on the same cycle as btn_l → offset=0, active_src=1. Then an A→A regrant with offset=1 keeps offset=1.
6. Assert rst=0 asynchronously between edges while a grant is pending → outputs reset at once with no clock edge. After release, the still-held valid is granted at the first boundary (16 cycles).
